// File: rtl/gpr_pkg.sv
// Shared definitions for the general-purpose register file and its clients.
// Holds the register file geometry, address/data types and the write-port
// record used by the write-back arbiter, the register file and decode.
package gpr_pkg;

    localparam int GPR_AW   = 5;
    localparam int GPR_DW   = 32;
    localparam int GPR_NREG = 32;

    typedef logic [GPR_AW-1:0] gpr_addr_t;
    typedef logic [GPR_DW-1:0] gpr_data_t;

    typedef struct packed {
        logic      we;
        gpr_addr_t addr;
        gpr_data_t data;
    } gpr_wr_t;

endpackage

// File: rtl/gpr_wb_arbiter_rr_arbiter.sv
// rr_arbiter: picks one requester out of a request vector.
// Build option GPR_WB_FAIR_EN:
//   defined   - rotating search starting at ptr (round robin)
//   undefined - fixed priority, requester 0 highest; no ptr port
// Ports:
//   req      in  NREQ  request vector
//   ptr      in  IW    first index searched (GPR_WB_FAIR_EN only)
//   gnt      out NREQ  one-hot grant, zero when no request
//   gnt_idx  out IW    encoded index of the grant (0 when none)
module rr_arbiter
    import gpr_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
`ifdef GPR_WB_FAIR_EN
    input  logic [IW-1:0]   ptr,
`endif
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 0; off < NREQ; off++) begin
`ifdef GPR_WB_FAIR_EN
            idx = (int'(ptr) + off) % NREQ;
`else
            idx = off;
`endif
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: shares the register file's single write port between
// NREQ write-back requesters with a valid/ready handshake and drives a
// registered write stage (Sw/Sc/Sin) straight into the register file.
// Writes to r0 complete their handshake but never reach the file.
// Build option GPR_WB_FAIR_EN: round-robin when defined, fixed priority
// (requester 0 highest) when undefined.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    in  NREQ      requester has a write pending
//   req_addr     in  NREQ*AW   destination register per requester
//   req_data     in  NREQ*DW   write data per requester
//   req_ready    out NREQ      one-hot grant; transfer when valid & ready
//   wb_hold      in  1         block new grants
//   Sw, Sc, Sin  out           register file write enable/address/data
//   grant_id     out IW        requester whose write is on Sw/Sc/Sin
//   busy         out 1         any req_valid high
module gpr_wb_arbiter
    import gpr_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int AW   = GPR_AW,
    parameter  int DW   = GPR_DW,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic              wb_hold,
    output logic              Sw,
    output logic [AW-1:0]     Sc,
    output logic [DW-1:0]     Sin,
    output logic [IW-1:0]     grant_id,
    output logic              busy
);

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            xfer;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    logic            sw_q, sw_d;
    logic [AW-1:0]   sc_q, sc_d;
    logic [DW-1:0]   sin_q, sin_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
`ifdef GPR_WB_FAIR_EN
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
`ifdef GPR_WB_FAIR_EN
        .ptr     (rr_ptr_q),
`endif
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Grants are suppressed during reset as well as under hold, so nothing
    // can handshake while the output stage is cleared.
    assign req_ready = (rst_n && !wb_hold) ? gnt : '0;
    assign xfer      = |req_ready;
    assign busy      = |req_valid;
    assign sel_addr  = req_addr[int'(gnt_idx)*AW +: AW];
    assign sel_data  = req_data[int'(gnt_idx)*DW +: DW];

    always_comb begin
        sw_d       = 1'b0;
        sc_d       = sc_q;
        sin_d      = sin_q;
        grant_id_d = grant_id_q;
`ifdef GPR_WB_FAIR_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        if (xfer) begin
`ifdef GPR_WB_FAIR_EN
            rr_ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif
            // r0 writes are consumed here; the write stage keeps showing the
            // last real write so grant_id always matches Sc/Sin.
            if (sel_addr != '0) begin
                sw_d       = 1'b1;
                sc_d       = sel_addr;
                sin_d      = sel_data;
                grant_id_d = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_q       <= 1'b0;
            sc_q       <= '0;
            sin_q      <= '0;
            grant_id_q <= '0;
`ifdef GPR_WB_FAIR_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            sw_q       <= sw_d;
            sc_q       <= sc_d;
            sin_q      <= sin_d;
            grant_id_q <= grant_id_d;
`ifdef GPR_WB_FAIR_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign Sw       = sw_q;
    assign Sc       = sc_q;
    assign Sin      = sin_q;
    assign grant_id = grant_id_q;

endmodule

// File: doc/gpr_wb_arbiter.md
# gpr_wb_arbiter

Write-back arbiter for the 32×32 general-purpose register file. It shares the file's single write port (Sw/Sc/Sin) between NREQ write-back requesters (ALU, load unit, multiplier, …) using a valid/ready handshake and round-robin grant. It drives a registered write stage directly into the register file's write port. Writes to r0 are accepted and dropped here, so the file never sees them.

## Interface
Parameters:
- NREQ, 4, number of write-back requesters (2..8)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i has a write pending
- req_addr  in  NREQ*AW  destination register, slice i = [i*AW +: AW]
- req_data  in  NREQ*DW  write data, slice i = [i*DW +: DW]
- req_ready  out  NREQ  one-hot (or zero) grant; transfer when valid&ready
- wb_hold  in  1  register-file owner blocks new grants
- Sw  out  1  write enable to register file
- Sc  out  AW  write address to register file
- Sin  out  DW  write data to register file
- grant_id  out  $clog2(NREQ)  index of requester whose write is on Sw/Sc/Sin
- busy  out  1  any req_valid high this cycle

## Operation
- Each cycle with wb_hold=0, grant at most one valid requester. req_ready is combinational from req_valid, pointer, and wb_hold.
- Round-robin: search starts at rr_ptr. On a transfer by requester g, rr_ptr <= (g+1) mod NREQ. With no transfer, rr_ptr holds.
- Transferred write is captured into the output stage: Sw<=1, Sc<=addr, Sin<=data, grant_id<=g. With no transfer, Sw<=0; Sc/Sin/grant_id hold their last values.
- r0 drop: a transfer with addr==0 completes the handshake and advances rr_ptr, but Sw<=0.
- wb_hold=1: req_ready=0 for all requesters and Sw<=0 next cycle. rr_ptr holds.
- Requesters must hold valid/addr/data stable until ready. The arbiter never revokes a grant within a cycle.
- Same-address writes from different requesters reach the file in grant order; the later grant wins.
- busy is combinational OR of req_valid.

## Timing
- Reset values: Sw=0, Sc=0, Sin=0, grant_id=0, rr_ptr=0. req_ready is 0 while rst_n=0.
- Latency: transfer in cycle N, Sw high during N+1, register-file contents updated at end of N+1, visible on read ports in N+2.
- Throughput: one write per cycle sustained.
- Worst-case wait for a continuously valid requester with wb_hold=0 is NREQ-1 cycles.
- Reset asserted mid-operation: the output stage clears immediately (Sw=0 asynchronously), so an in-flight write is lost. Requesters must re-present after reset.
- rr_ptr wraps from NREQ-1 to 0.

## Configuration
- GPR_WB_FAIR_EN defined: round-robin arbitration as above.
- GPR_WB_FAIR_EN undefined: fixed priority, requester 0 highest. rr_ptr logic is removed, and the starvation bound no longer applies.
- All other behaviour is identical in both builds.

## Structure
- Package gpr_pkg holds:
  - GPR_AW=5, GPR_DW=32, GPR_NREG=32
  - typedef gpr_addr_t, gpr_data_t
  - gpr_wr_t struct {we, addr, data}, shared with the register file and decode stage
- Sub-module rr_arbiter: NREQ request vector plus pointer in; one-hot grant and encoded index out. Holds the GPR_WB_FAIR_EN switch.
- Top level adds the data mux, the r0 drop, wb_hold gating, and the output register.

## Test plan
- Reset: rst_n=0 with all req_valid=1 -> req_ready=0, Sw=0, Sc=0, Sin=0. First grant after release goes to req 0.
- Single write: req1 valid, addr=7, data=0xDEADBEEF in cycle N -> req_ready=0b0010 in N. Sw=1, Sc=7, Sin=0xDEADBEEF, grant_id=1 in N+1. Reading r7 returns 0xDEADBEEF in N+2.
- Round-robin: all four valid, held continuously -> grants 0,1,2,3,0 on consecutive cycles. With GPR_WB_FAIR_EN undefined -> grant 0 every cycle.
- r0 drop: req2 writes addr=0, data=0xFFFFFFFF -> handshake completes and rr_ptr advances to 3. Sw stays 0, and r0 still reads 0.
- Hold: wb_hold=1 for 3 cycles with req0 valid -> req_ready=0 and Sw=0 throughout. Grant goes to req0 in the first cycle after release.
- Same-address order: req0 writes r5=0x11, then req1 writes r5=0x22 on the next grant -> r5 reads 0x22. Async reset mid-stream -> Sw drops to 0 the same cycle.
